me_scheduler: RTL and testbench
===============================

# me_scheduler

Control and accumulation unit for the motion estimator. It sequences reference-memory and search-memory reads over every candidate displacement of a 16x16 reference block inside a 32x32 search window. It accumulates the sum of absolute differences (SAD) on two parallel lanes and reports the best motion vector and distance. It sits between the testbench/system `start` source and the two pixel memories, and drives the estimator's result signals (`motionX`, `motionY`, `bestDistance`, `completed`).

## Interface
Parameters:
- `ACC_W`, default 16: SAD accumulator width. Must be ≥16 so that 256×255 cannot overflow.
- `DIST_W`, default 8: width of the reported `bestDistance`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a search
- `AddressR`  out  8  reference-memory address, `row*16+col`
- `AddressS1`  out  10  search-memory address for lane 1, `row*32+col`
- `AddressS2`  out  10  search-memory address for lane 2
- `R`, `S1`, `S2`  in  8 each  read data, valid one cycle after the address (synchronous read)
- `motionX`, `motionY`  out  4 each  best displacement index, 0..15 (signed offset = index−8)
- `bestDistance`  out  `DIST_W`  best SAD, saturated to 0xFF
- `completed`  out  1  result valid
- `busy`  out  1  search in progress

## Operation
- States: IDLE, RUN, DRAIN, UPDATE, DONE.
- IDLE/DONE with `start`=1 → RUN.
  - Clears pass counters `x`=0, `y`=0, `pr`=`pc`=0 and both accumulators.
  - Sets internal best = all ones, `completed`=0.
- `start` is ignored in RUN, DRAIN and UPDATE.
- A pass evaluates two candidates, lane 1 at (x, y) and lane 2 at (x+8, y), with x∈0..7 and y∈0..15. That gives 128 passes and 256 candidates.
- RUN: one pixel per cycle, `pc` inner and `pr` outer, each 0..15. Addresses issued:
  - `AddressR = pr*16+pc`
  - `AddressS1 = (y+pr)*32+(x+pc)`
  - `AddressS2 = (y+pr)*32+(x+8+pc)`
- Data returning one cycle later is added to each lane's accumulator:
  - Lane 1 adds |R−S1|; lane 2 adds |R−S2|.
  - Absolute difference is 8-bit unsigned, zero-extended to `ACC_W`.
- After the 256th address (`pr`=`pc`=15) → DRAIN: one cycle, accumulates the last pixel, no new address.
- UPDATE:
  - Lane 1 is compared first, then lane 2. A candidate replaces the best only if its SAD is strictly less. Ties keep the earlier candidate, so an earlier pass wins, and lane 1 wins within a pass.
  - Accumulators clear.
  - Increment x, wrapping 7→0 with y+1. After x=7, y=15 → DONE; otherwise → RUN.
- DONE:
  - `completed`=1, and `motionX`/`motionY`/`bestDistance` hold until the next accepted `start` or reset.
  - `bestDistance` = min(best, 2^`DIST_W`−1).
- `busy`=1 in RUN, DRAIN and UPDATE.
- Addresses hold their last value outside RUN. They are 0 after reset.

## Timing
- Reset values: all outputs 0. Internal best = all ones. State = IDLE.
- Reset is asynchronous and active-low. Assertion mid-search aborts immediately with the outputs above. No partial result is retained.
- Pass length: 256 RUN + 1 DRAIN + 1 UPDATE = 258 cycles.
- Latency: `completed` rises on edge 128×258 = 33024 after the edge that sampled `start`. Addresses for the first pixel appear after that same sampling edge.
- Restart from DONE: `completed` drops on the edge that samples `start`.
- The UPDATE compare uses accumulators that include the DRAIN pixel.

## Configuration
- `ME_EARLY_TERM_EN` defined:
  - In RUN, when both lane accumulators are already ≥ internal best, address issue stops and the block goes to DRAIN, then UPDATE. Any pixel still in flight is still accumulated.
  - Neither lane can win such a pass, so results are identical to full search; only latency shrinks and varies.
- Undefined: every pass runs the full 258 cycles, and latency is exactly 33024 cycles.

## Test plan
- Distinct-valued pattern block in R; S is all 0xFF except an exact copy at (x=3, y=5) → `motionX`=3, `motionY`=5, `bestDistance`=0. Without the macro, `completed` is high at edge 33024.
- Same setup with the copy at (11, 2) (lane 2) → `motionX`=11, `motionY`=2, `bestDistance`=0.
- All memories 0 (all candidates tie) → `motionX`=0, `motionY`=0, `bestDistance`=0.
- R all 0x00, S all 0xFF → every SAD = 65280 → `bestDistance`=0xFF, motion (0, 0).
- Address check on pass 1: `AddressS1` = 0..15, 32..47, …; `AddressS2` = 8..23, 40..55, …; `AddressR` = 0..255. A `start` pulse at cycle 100 is ignored.
- `rst_n` low at cycle 1000 → all outputs 0 immediately. A new `start` then reproduces the first scenario's result exactly.

Source files
------------

// File: rtl/me_scheduler_if.sv
// rtl/me_scheduler_if.sv - pixel memory bus between the motion-estimator scheduler and its reference/search memories
interface me_scheduler_if;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R;
  logic [7:0] S1;
  logic [7:0] S2;

  modport master (output AddressR, AddressS1, AddressS2, input R, S1, S2);
  modport slave  (input AddressR, AddressS1, AddressS2, output R, S1, S2);
endinterface

// File: rtl/me_scheduler.sv
// rtl/me_scheduler.sv - full-search SAD scheduler, 16x16 block in 32x32 window, two lanes per pass
// Optional feature: define ME_EARLY_TERM_EN to abandon a pass once neither lane can beat the best SAD.
module me_scheduler #(
  parameter int ACC_W  = 16,
  parameter int DIST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  me_scheduler_if.master    mem,
  output logic [3:0]        motionX,
  output logic [3:0]        motionY,
  output logic [DIST_W-1:0] bestDistance,
  output logic              completed,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, UPDATE, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         x_q, x_d;
  logic [3:0]         y_q, y_d, pr_q, pr_d, pc_q, pc_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d, best_q, best_d;
  logic [3:0]         bx_q, bx_d, by_q, by_d;
  logic               issued_q;
  logic [7:0]         ar_q, ar_d;
  logic [9:0]         as1_q, as1_d, as2_q, as2_d;
  logic [3:0]         mx_q, mx_d, my_q, my_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               done_q, done_d;

  function automatic logic [9:0] s_addr(input logic [3:0] yy, input logic [3:0] rr,
                                        input logic [4:0] xx, input logic [3:0] cc);
    logic [4:0] row;
    logic [4:0] col;
    row = {1'b0, yy} + {1'b0, rr};
    col = xx + {1'b0, cc};
    return {row, col};
  endfunction

  logic [7:0]        ad1, ad2;
  logic [ACC_W-1:0]  sum1, sum2;
  assign ad1  = (mem.R > mem.S1) ? (mem.R - mem.S1) : (mem.S1 - mem.R);
  assign ad2  = (mem.R > mem.S2) ? (mem.R - mem.S2) : (mem.S2 - mem.R);
  assign sum1 = acc1_q + {{(ACC_W-8){1'b0}}, ad1};
  assign sum2 = acc2_q + {{(ACC_W-8){1'b0}}, ad2};

  // Lane 1 is offered to the best first so that it wins ties inside a pass.
  logic              win1, win2;
  logic [ACC_W-1:0]  best1, best_new;
  logic [3:0]        bx_new, by_new;
  logic [DIST_W-1:0] sat_new;
  assign win1     = acc1_q < best_q;
  assign best1    = win1 ? acc1_q : best_q;
  assign win2     = acc2_q < best1;
  assign best_new = win2 ? acc2_q : best1;
  assign bx_new   = win2 ? {1'b1, x_q} : (win1 ? {1'b0, x_q} : bx_q);
  assign by_new   = (win1 || win2) ? y_q : by_q;
  assign sat_new  = (|best_new[ACC_W-1:DIST_W]) ? {DIST_W{1'b1}} : best_new[DIST_W-1:0];

  logic       last_x;
  logic [2:0] x_nx;
  logic [3:0] y_nx;
  assign last_x = (x_q == 3'd7);
  assign x_nx   = x_q + 3'd1;
  assign y_nx   = last_x ? (y_q + 4'd1) : y_q;

  logic prune;
`ifdef ME_EARLY_TERM_EN
  assign prune = (acc1_q >= best_q) && (acc2_q >= best_q);
`else
  assign prune = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d = x_q;   y_d = y_q;   pr_d = pr_q;   pc_d = pc_q;
    acc1_d = acc1_q;   acc2_d = acc2_q;   best_d = best_q;
    bx_d = bx_q;   by_d = by_q;
    ar_d = ar_q;   as1_d = as1_q;   as2_d = as2_q;
    mx_d = mx_q;   my_d = my_q;   dist_d = dist_q;   done_d = done_q;
    // Data for the address presented last cycle arrives now.
    if (issued_q) begin
      acc1_d = sum1;
      acc2_d = sum2;
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          x_d = 3'd0;   y_d = 4'd0;   pr_d = 4'd0;   pc_d = 4'd0;
          acc1_d = '0;  acc2_d = '0;  best_d = '1;
          bx_d = 4'd0;  by_d = 4'd0;
          mx_d = 4'd0;  my_d = 4'd0;  dist_d = '0;  done_d = 1'b0;
          ar_d = 8'd0;  as1_d = 10'd0; as2_d = 10'd8;
        end
      end
      RUN: begin
        if (prune || (pr_q == 4'd15 && pc_q == 4'd15)) begin
          state_d = DRAIN;
        end else begin
          pc_d = pc_q + 4'd1;
          if (pc_q == 4'd15) pr_d = pr_q + 4'd1;
          ar_d  = {pr_d, pc_d};
          as1_d = s_addr(y_q, pr_d, {2'b00, x_q}, pc_d);
          as2_d = s_addr(y_q, pr_d, {2'b01, x_q}, pc_d);
        end
      end
      DRAIN: state_d = UPDATE;
      UPDATE: begin
        acc1_d = '0;  acc2_d = '0;  pr_d = 4'd0;  pc_d = 4'd0;
        best_d = best_new;  bx_d = bx_new;  by_d = by_new;
        if (last_x && y_q == 4'd15) begin
          state_d = DONE;
          done_d  = 1'b1;
          mx_d = bx_new;  my_d = by_new;  dist_d = sat_new;
        end else begin
          state_d = RUN;
          x_d = x_nx;  y_d = y_nx;
          ar_d  = 8'd0;
          as1_d = s_addr(y_nx, 4'd0, {2'b00, x_nx}, 4'd0);
          as2_d = s_addr(y_nx, 4'd0, {2'b01, x_nx}, 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= 3'd0;  y_q <= 4'd0;  pr_q <= 4'd0;  pc_q <= 4'd0;
      acc1_q <= '0;  acc2_q <= '0;  best_q <= '1;
      bx_q <= 4'd0;  by_q <= 4'd0;  issued_q <= 1'b0;
      ar_q <= 8'd0;  as1_q <= 10'd0;  as2_q <= 10'd0;
      mx_q <= 4'd0;  my_q <= 4'd0;  dist_q <= '0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  pr_q <= pr_d;  pc_q <= pc_d;
      acc1_q <= acc1_d;  acc2_q <= acc2_d;  best_q <= best_d;
      bx_q <= bx_d;  by_q <= by_d;  issued_q <= (state_q == RUN);
      ar_q <= ar_d;  as1_q <= as1_d;  as2_q <= as2_d;
      mx_q <= mx_d;  my_q <= my_d;  dist_q <= dist_d;  done_q <= done_d;
    end
  end

  assign mem.AddressR  = ar_q;
  assign mem.AddressS1 = as1_q;
  assign mem.AddressS2 = as2_q;
  assign motionX       = mx_q;
  assign motionY       = my_q;
  assign bestDistance  = dist_q;
  assign completed     = done_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN) || (state_q == UPDATE);

endmodule

// File: tb/tb_me_scheduler.sv
// tb/tb_me_scheduler.sv - directed scoreboard bench for me_scheduler with behavioural pixel memories
module tb_me_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] motionX, motionY;
  logic [7:0] bestDistance;
  logic       completed, busy;

  me_scheduler_if mif();

  me_scheduler #(.ACC_W(16), .DIST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem(mif),
    .motionX(motionX), .motionY(motionY), .bestDistance(bestDistance),
    .completed(completed), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [256];
  logic [7:0] srch_mem [1024];

  always @(posedge clk) begin
    mif.R  <= ref_mem[mif.AddressR];
    mif.S1 <= srch_mem[mif.AddressS1];
    mif.S2 <= srch_mem[mif.AddressS2];
  end

  typedef struct {
    logic [3:0] mx;
    logic [3:0] my;
    logic [7:0] d;
  } res_t;
  res_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference search in candidate scan order: y, then x, then lane 1 before lane 2.
  task automatic push_model();
    int best;
    res_t r;
    best = 65535;
    r.mx = 4'd0;  r.my = 4'd0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++)
        for (int l = 0; l < 2; l++) begin
          int cx;
          int sad;
          cx  = x + 8 * l;
          sad = 0;
          for (int rr = 0; rr < 16; rr++)
            for (int cc = 0; cc < 16; cc++) begin
              int a;
              int b;
              a = int'(ref_mem[rr * 16 + cc]);
              b = int'(srch_mem[(y + rr) * 32 + cx + cc]);
              sad += (a > b) ? (a - b) : (b - a);
            end
          if (sad < best) begin
            best = sad;
            r.mx = 4'(cx);
            r.my = 4'(y);
          end
        end
    r.d = (best > 255) ? 8'hFF : 8'(best);
    exp_q.push_back(r);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_motionX"}, motionX, 0);
    check({tag, "_motionY"}, motionY, 0);
    check({tag, "_bestDistance"}, bestDistance, 0);
    check({tag, "_completed"}, completed, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_AddressR"}, mif.AddressR, 0);
    check({tag, "_AddressS1"}, mif.AddressS1, 0);
    check({tag, "_AddressS2"}, mif.AddressS2, 0);
  endtask

  task automatic run_search(input bit chk_addr, input int abort_at);
    int cnt;
    res_t r;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    check("busy_after_start", busy, 1);
    check("completed_low_after_start", completed, 0);
    while (completed !== 1'b1 && cnt < 40000) begin
      if (chk_addr && cnt < 256) begin
        check("AddressR", mif.AddressR, cnt);
        check("AddressS1", mif.AddressS1, (cnt / 16) * 32 + cnt % 16);
        check("AddressS2", mif.AddressS2, (cnt / 16) * 32 + cnt % 16 + 8);
      end
      if (chk_addr && cnt == 256) check("AddressR_hold_drain", mif.AddressR, 255);
      if (chk_addr && cnt == 100) start = 1'b1;
      if (chk_addr && cnt == 101) start = 1'b0;
      if (abort_at > 0 && cnt == abort_at) begin
        check("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("abort_held");
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    check("completed", completed, 1);
    check("busy_done", busy, 0);
`ifndef ME_EARLY_TERM_EN
    check("latency", cnt, 33024);
`endif
    check("scoreboard_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("motionX", motionX, r.mx);
      check("motionY", motionY, r.my);
      check("bestDistance", bestDistance, r.d);
    end
    repeat (3) @(posedge clk);
    #1;
    check("completed_hold", completed, 1);
  endtask

  initial begin
    // Scenario A: distinct-valued block copied exactly at (3,5), lane 1 winner.
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    for (int i = 0; i < 1024; i++) srch_mem[i] = 8'hFF;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) srch_mem[(5 + r) * 32 + 3 + c] = ref_mem[r * 16 + c];

    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    push_model();
    run_search(1'b1, 0);

    // Scenario B: R zero, S=2 over columns 11..27 rows 2..17; (11,2) and (12,2) tie at SAD 512.
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) srch_mem[i] = 8'hFF;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 17; c++) srch_mem[(2 + r) * 32 + 11 + c] = 8'h02;

    run_search(1'b0, 1000);

    push_model();
    run_search(1'b0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
